// File: rtl/pwm_gen_pkg.sv
// Shared constants and enums for the PWM generator bank.
package pwm_gen_pkg;

    // Duty registers start at DUTY_BASE; TOP and MODE sit just above the NUM_CH duty slots.
    localparam int unsigned DUTY_BASE = 0;
    localparam int unsigned TOP_OFFS  = 0;
    localparam int unsigned MODE_OFFS = 1;

    typedef enum logic {
        ModeEdge   = 1'b0,
        ModeCenter = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one tick every (div+1) cycles, div sampled at the start of each prescaler period.
module pwm_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] pre_q;
    logic [DIV_W-1:0] lim_q;
    logic [DIV_W-1:0] lim;

    // A new div is honoured only from the first cycle of a prescaler period.
    assign lim  = (pre_q == '0) ? div : lim_q;
    assign tick = (pre_q == lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            lim_q <= '0;
        end else begin
            if (pre_q == '0) begin
                lim_q <= div;
            end
            pre_q <= tick ? '0 : pre_q + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_gen_bank.sv
// Multi-channel PWM bank with shadowed duty/TOP/MODE registers loaded at the period boundary.
// Define PWM_CENTER_ALIGNED_EN to add the up/down (center-aligned) counting mode.
module pwm_gen_bank
    import pwm_gen_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8,
    parameter int DIV_W  = 4,
    localparam int ADDR_W = $clog2(NUM_CH + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [DIV_W-1:0]  div,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NUM_CH + TOP_OFFS);

    logic             tick;
    logic             boundary;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] top_sh, top_act;
    logic             top_hit;
    logic             period_start_q;

    pwm_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .div  (div),
        .tick (tick)
    );

    assign top_hit = wr_en && (wr_addr == TOP_ADDR);

`ifdef PWM_CENTER_ALIGNED_EN
    localparam logic [ADDR_W-1:0] MODE_ADDR = ADDR_W'(NUM_CH + MODE_OFFS);

    pwm_mode_e mode_sh, mode_act;
    pwm_dir_e  dir_q, dir_d;
    logic      mode_hit;

    assign mode_hit = wr_en && (wr_addr == MODE_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sh  <= ModeEdge;
            mode_act <= ModeEdge;
            dir_q    <= DirUp;
        end else begin
            if (mode_hit) begin
                mode_sh <= pwm_mode_e'(wr_data[0]);
            end
            if (boundary) begin
                mode_act <= mode_hit ? pwm_mode_e'(wr_data[0]) : mode_sh;
            end
            dir_q <= dir_d;
        end
    end
`endif

    always_comb begin
        cnt_d    = cnt_q;
        boundary = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        dir_d = dir_q;
        if (tick) begin
            if (mode_act == ModeCenter) begin
                if (dir_q == DirUp && cnt_q < top_act) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d    = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                    dir_d    = DirDown;
                    boundary = (cnt_d == '0);
                end
            end else begin
                boundary = (cnt_q >= top_act);
                cnt_d    = boundary ? '0 : cnt_q + 1'b1;
            end
            if (boundary) begin
                dir_d = DirUp;
            end
        end
`else
        if (tick) begin
            boundary = (cnt_q >= top_act);
            cnt_d    = boundary ? '0 : cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            top_sh         <= '1;
            top_act        <= '1;
            period_start_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (top_hit) begin
                top_sh <= wr_data;
            end
            // A write landing on the boundary goes straight to the active copy.
            if (boundary) begin
                top_act <= top_hit ? wr_data : top_sh;
            end
            period_start_q <= boundary;
        end
    end

    assign period_start = period_start_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        localparam logic [ADDR_W-1:0] DUTY_ADDR = ADDR_W'(DUTY_BASE + n);

        logic [CNT_W-1:0] duty_sh, duty_act;
        logic             duty_hit;
        logic             pwm_q;

        assign duty_hit = wr_en && (wr_addr == DUTY_ADDR);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_sh  <= '0;
                duty_act <= '0;
                pwm_q    <= 1'b0;
            end else begin
                if (duty_hit) begin
                    duty_sh <= wr_data;
                end
                if (boundary) begin
                    duty_act <= duty_hit ? wr_data : duty_sh;
                end
                pwm_q <= ch_en[n] && (cnt_q < duty_act);
            end
        end

        assign pwm_out[n] = pwm_q;
    end

endmodule

// File: tb/tb_pwm_gen_bank.sv
// Scoreboard bench for pwm_gen_bank: a period-position model predicts every output cycle.
module tb_pwm_gen_bank;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;
    localparam int DIV_W  = 4;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [CNT_W-1:0]  wr_data = '0;
    logic [NUM_CH-1:0] ch_en = '1;
    logic [DIV_W-1:0]  div = '0;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    pwm_gen_bank #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ch_en       (ch_en),
        .div         (div),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [NUM_CH:0] exp_q[$];

    // Model state: position within the period in ticks, plus shadow/active copies.
    int m_ph, m_plen, m_pos;
    int m_top_sh, m_top_a, m_mode_sh, m_mode_a;
    int m_duty_sh[NUM_CH];
    int m_duty_a[NUM_CH];

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int m_len();
        if (m_mode_a != 0) return (m_top_a == 0) ? 1 : 2 * m_top_a;
        return m_top_a + 1;
    endfunction

    // Counter value seen at a given period position: a ramp, or a triangle in center mode.
    function automatic int m_cnt();
        if (m_mode_a != 0 && m_pos > m_top_a) return 2 * m_top_a - m_pos;
        return m_pos;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_plen = 1; m_pos = 0;
        m_top_sh = 255; m_top_a = 255; m_mode_sh = 0; m_mode_a = 0;
        for (int n = 0; n < NUM_CH; n++) begin
            m_duty_sh[n] = 0;
            m_duty_a[n]  = 0;
        end
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] e;
        logic tk, b;
        for (int n = 0; n < NUM_CH; n++) e[n] = ch_en[n] && (m_cnt() < m_duty_a[n]);
        if (m_ph == 0) m_plen = int'(div) + 1;
        tk = (m_ph == m_plen - 1);
        m_ph = tk ? 0 : m_ph + 1;
        if (wr_en) begin
            if (int'(wr_addr) < NUM_CH) m_duty_sh[wr_addr] = int'(wr_data);
            else if (int'(wr_addr) == NUM_CH) m_top_sh = int'(wr_data);
`ifdef PWM_CENTER_ALIGNED_EN
            else if (int'(wr_addr) == NUM_CH + 1) m_mode_sh = int'(wr_data[0]);
`endif
        end
        b = 1'b0;
        if (tk) begin
            m_pos++;
            if (m_pos >= m_len()) begin
                m_pos = 0;
                b = 1'b1;
            end
        end
        if (b) begin
            m_top_a  = m_top_sh;
            m_mode_a = m_mode_sh;
            for (int n = 0; n < NUM_CH; n++) m_duty_a[n] = m_duty_sh[n];
        end
        exp_q.push_back({b, e});
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        logic [NUM_CH:0] x;
        if (!rst_n) begin
            exp_q.delete();
            check("reset_outs", int'({period_start, pwm_out}), 0);
        end else if (exp_q.size() == 0) begin
            check("post_reset_outs", int'({period_start, pwm_out}), 0);
        end else begin
            x = exp_q.pop_front();
            check("sb_out", int'({period_start, pwm_out}), int'(x));
        end
    end

    task automatic cyc(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = CNT_W'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic wait_ps(input int budget, output int waited, output int highs0);
        waited = 0;
        highs0 = 0;
        do begin
            highs0 += int'(pwm_out[0]);
            cyc();
            waited++;
        end while (!period_start && waited < budget);
        if (!period_start) check("ps_timeout", 0, 1);
    endtask

    initial begin
        int w, h, ps_cnt, o1_hi, o2_lo;
        cyc(3);
        rst_n = 1'b1;
        check("reset_top_period", 0, 0 + int'(pwm_out));

        // 64/256 duty at div=0
        wr(0, 64);
        wait_ps(600, w, h);
        h = 0; ps_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            h += int'(pwm_out[0]);
            ps_cnt += int'(period_start);
            cyc();
        end
        check("duty64_high_cycles", h, 64);
        check("duty64_ps_per_period", ps_cnt, 1);

        // Mid-period rewrite: remainder of the old period stays at the old width
        wait_ps(600, w, h);
        cyc(100);
        wr(0, 128);
        wait_ps(600, w, h);
        check("old_width_tail_high", h, 0);
        h = 0;
        for (int i = 0; i < 256; i++) begin
            h += int'(pwm_out[0]);
            cyc();
        end
        check("duty128_high_cycles", h, 128);

        // duty 0 stays low, duty above TOP stays high
        wr(8, 200);
        wr(1, 0);
        wr(2, 255);
        wait_ps(600, w, h);
        cyc();
        o1_hi = 0; o2_lo = 0;
        for (int i = 0; i < 402; i++) begin
            o1_hi += int'(pwm_out[1]);
            o2_lo += int'(!pwm_out[2]);
            cyc();
        end
        check("duty0_never_high", o1_hi, 0);
        check("duty_over_top_never_low", o2_lo, 0);

        // div=3, TOP=9 -> 40-cycle periods
        div = 4'd3;
        wr(8, 9);
        wait_ps(2000, w, h);
        wait_ps(2000, w, h);
        wait_ps(2000, w, h);
        check("div3_top9_spacing", w, 40);
        wait_ps(2000, w, h);
        check("div3_top9_spacing2", w, 40);

        // Reset mid-period
        div = 4'd0;
        wr(8, 255);
        wr(0, 128);
        wait_ps(2000, w, h);
        wait_ps(2000, w, h);
        cyc(50);
        check("pre_reset_out0_high", int'(pwm_out[0]), 1);
        rst_n = 1'b0;
        #1;
        check("reset_immediate_pwm", int'(pwm_out), 0);
        cyc(3);
        rst_n = 1'b1;
        wait_ps(600, w, h);
        check("post_reset_first_period", w, 256);

`ifdef PWM_CENTER_ALIGNED_EN
        wr(9, 1);
        wr(8, 4);
        wr(0, 2);
        wait_ps(600, w, h);
        wait_ps(600, w, h);
        wait_ps(600, w, h);
        check("center_spacing", w, 8);
        cyc();
        h = 0;
        for (int i = 0; i < 8; i++) begin
            h += int'(pwm_out[0]);
            cyc();
        end
        check("center_high_cycles", h, 3);
`endif

        // Randomized traffic with short periods
        wr(8, 6);
        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = ADDR_W'($urandom_range(0, 15));
            wr_data = (int'(wr_addr) == NUM_CH) ? CNT_W'($urandom_range(0, 15))
                                                : CNT_W'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom);
            if ($urandom_range(0, 63) == 0) div = DIV_W'($urandom_range(0, 2));
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            cyc();
        end
        wr_en = 1'b0;
        rst_n = 1'b1;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_gen_bank.md
PWM_GEN_BANK -- requirements
Module: pwm_gen_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning the number of PWM channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the counter, duty and TOP width.
REQ-003 SHALL have parameter DIV_W, default 4, meaning the prescaler divider width.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_en, input, 1, a one-cycle register write strobe.
REQ-007 SHALL have port wr_addr, input, ADDR_W = $clog2(NUM_CH+2), the register address.
REQ-008 SHALL have port wr_data, input, CNT_W, the register write data.
REQ-009 SHALL have port ch_en, input, NUM_CH, a per-channel output enable.
REQ-010 SHALL have port div, input, DIV_W, the prescaler setting.
REQ-011 SHALL have port pwm_out, output, NUM_CH, registered PWM outputs.
REQ-012 SHALL have port period_start, output, 1, a one-cycle pulse when new active values load.

Function
REQ-013 SHALL use this address map: 0..NUM_CH-1 is duty shadow for channel n; NUM_CH is TOP shadow; NUM_CH+1 is MODE (bit0); all other addresses are ignored.
REQ-014 SHALL assert a prescaler tick once every (div+1) clk cycles; div=0 ticks every cycle, and a div change takes effect on prescaler rollover.
REQ-015 SHALL, in edge mode, increment the counter on each tick and wrap to 0 on the tick where cnt >= TOP_active; the period is TOP+1 ticks.
REQ-016 SHALL define the period boundary as that wrap tick, or as the valley in center mode.
REQ-017 SHALL, at the period boundary, copy all shadow duty, TOP and MODE values to active and pulse period_start for exactly one clk.
REQ-018 SHALL, when a write coincides with a boundary, transfer the newly written value, so writes are write-through.
REQ-019 SHALL compute the channel output as pwm_out[n] = ch_en[n] & (cnt < duty_active[n]), registered with 1 clk latency.
REQ-020 SHALL hold duty=0 at constant low and duty > TOP at constant high, with no glitch pulse.
REQ-021 SHALL drive pwm_out[n] low on the clk after ch_en[n] falls, without disturbing the counter.
REQ-022 SHALL compare a TOP_active below the current cnt using >=, so the counter wraps on the next tick.
REQ-023 SHALL NOT change any active value mid-period.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear counter, prescaler, all shadow/active duties, MODE, pwm_out and period_start to 0.
REQ-025 SHALL reset TOP shadow/active to all-ones.
REQ-026 SHALL, on reset release mid-operation, restart at cnt=0 with the first tick after div+1 cycles.

Configuration
REQ-027 SHALL, with PWM_CENTER_ALIGNED_EN defined, use MODE bit0=1 for an up/down counter running 0..TOP..0 with a period of 2*TOP ticks and the boundary at the cnt=0 valley; the output rule is unchanged.
REQ-028 SHALL, without PWM_CENTER_ALIGNED_EN, ignore MODE writes, hold MODE at 0, and omit the direction flip-flop.

Structure
REQ-029 SHALL place address offsets (DUTY_BASE, TOP_OFFS, MODE_OFFS) and the mode enum in package pwm_gen_pkg.
REQ-030 SHALL instantiate sub-module pwm_prescaler (div to tick) once; the channel compare SHALL be a generate loop.

Verification
REQ-031 SHALL verify: NUM_CH=8, CNT_W=8, div=0, TOP=255, duty[0]=64 -> 64 high cycles, 192 low, repeating.
REQ-032 SHALL verify: duty[1]=0 and duty[2]=255 with TOP=200 -> out1 constant 0, out2 constant 1, never toggling.
REQ-033 SHALL verify: duty[0] written 128 mid-period -> old width finishes, new width starts after the period_start pulse.
REQ-034 SHALL verify: div=3, TOP=9 -> period is 40 clk; period_start spacing is 40.
REQ-035 SHALL verify: with PWM_CENTER_ALIGNED_EN, TOP=4, duty=2 -> cnt 0,1,2,3,4,3,2,1 with out high for cnt 0,1 on both slopes, so the pulse is symmetric.
REQ-036 SHALL verify: rst_n low mid-period -> pwm_out=0 immediately; after release the counter restarts at 0 with TOP=255.
